alu8_accum_ctrl: RTL

Command-side controller for the 8-bit ALU. It owns an accumulator and accepts commands over a valid/ready handshake. For each ALU command it drives the ALU operand and opcode ports, waits the ALU latency, captures the result and flags, and returns them over a valid/ready response channel. It sits between a host/sequencer and the combinational or registered alu8bit instance.

---
 rtl/alu8_accum_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/alu8_accum_ctrl.sv
// Accumulator/command controller sitting in front of an 8-bit ALU instance.
// Optional macro ACCUM_STICKY_FLAGS_EN adds sticky carry/overflow tracking and the CLRSTICKY op.
module alu8_accum_ctrl #(
  parameter int WIDTH   = 8,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
`ifdef ACCUM_STICKY_FLAGS_EN
  output logic [1:0]       sticky_o,
`endif
  output logic [WIDTH-1:0] acc_o,
  output logic [3:0]       flags_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_CMP     = 3'b101;
  localparam logic [3:0] OP_LOAD    = 4'b1000;
  localparam logic [3:0] OP_CLEAR   = 4'b1001;
  localparam logic [3:0] CLEAR_FLAGS = 4'b0001;
  localparam logic [2:0] LAT_START  = 3'(ALU_LAT - 1);

  state_t           state;
  logic [2:0]       lat_cnt;
  logic             is_alu;
  logic             is_load;
  logic             is_clear;
  logic             is_clrsticky;
  logic [3:0]       load_flags;
  logic             accept;

  assign cmd_ready = (state == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  // Command decode; anything not claimed here falls through as illegal.
  always_comb begin
    is_alu       = 1'b0;
    is_load      = 1'b0;
    is_clear     = 1'b0;
    is_clrsticky = 1'b0;
    load_flags   = {cmd_data[WIDTH-1], 1'b0, 1'b0, (cmd_data == '0)};
    if (!cmd_op[3] && (cmd_op[2:0] <= OP_CMP)) begin
      is_alu = 1'b1;
    end
    if (cmd_op == OP_LOAD) begin
      is_load = 1'b1;
    end
    if (cmd_op == OP_CLEAR) begin
      is_clear = 1'b1;
    end
`ifdef ACCUM_STICKY_FLAGS_EN
    if (cmd_op == 4'b1010) begin
      is_clrsticky = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
      acc_o      <= '0;
      flags_o    <= '0;
`ifdef ACCUM_STICKY_FLAGS_EN
      sticky_o   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_err <= 1'b0;
            if (is_alu) begin
              alu_a   <= acc_o;
              alu_b   <= cmd_data;
              alu_op  <= cmd_op[2:0];
              lat_cnt <= LAT_START;
              state   <= EXEC;
            end else if (is_load) begin
              acc_o      <= cmd_data;
              flags_o    <= load_flags;
              rsp_result <= cmd_data;
              rsp_flags  <= load_flags;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end else if (is_clear) begin
              acc_o      <= '0;
              flags_o    <= CLEAR_FLAGS;
              rsp_result <= '0;
              rsp_flags  <= CLEAR_FLAGS;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end else if (is_clrsticky) begin
`ifdef ACCUM_STICKY_FLAGS_EN
              sticky_o   <= '0;
`endif
              rsp_result <= acc_o;
              rsp_flags  <= flags_o;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end else begin
              rsp_err    <= 1'b1;
              rsp_result <= acc_o;
              rsp_flags  <= flags_o;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end
          end
        end

        // Operands stay parked on alu_* while the ALU settles; compare never writes acc.
        EXEC: begin
          if (lat_cnt == '0) begin
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
            flags_o    <= alu_flags;
            if (alu_op != OP_CMP) begin
              acc_o <= alu_result;
            end
`ifdef ACCUM_STICKY_FLAGS_EN
            sticky_o   <= sticky_o | alu_flags[2:1];
`endif
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
